// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver and key-state decoder.
// Samples the raw PS/2 lines in the clk domain and deframes 11-bit frames.
// Each frame is checked for start, odd parity, stop and timeout. The decoder
// tracks the E0 (extended) and F0 (break) prefixes and keeps held state plus
// press/release pulses for NUM_KEYS configurable key slots.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk         raw PS/2 clock (asynchronous)
//   ps2_data        raw PS/2 data (asynchronous)
//   key_held        level per slot, 1 while the key is down
//   key_press       1-cycle pulse on make of a key that was not held
//   key_release     1-cycle pulse on break of a held key
//   scan_code       last valid received byte
//   scan_valid      1-cycle pulse when scan_code updates
//   frame_err       1-cycle pulse on bad start/parity/stop or timeout
module ps2_key_decoder #(
  parameter int unsigned               NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0]     KEY_CODES      = {8'h72, 8'h75, 8'h76, 8'h29},
  parameter logic [NUM_KEYS-1:0]       KEY_EXT        = '0,
  parameter int unsigned               TIMEOUT_CYCLES = 50000,
  parameter int unsigned               FILTER_LEN     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [7:0]          scan_code,
  output logic                scan_valid,
  output logic                frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, state_next;
  logic [1:0]      clk_sync, data_sync;
  logic            clk_filt, clk_filt_q;
  logic [FW-1:0]   fcnt;
  logic            fall, data_s;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TW-1:0]   tcnt;
  logic            timeout, frame_ok, frame_bad;
  logic            brk, ext;

  // Input synchronisers; idle bus level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Glitch filter: the filtered clock follows the synchronised clock only
  // after FILTER_LEN consecutive samples disagree with its current level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      fcnt       <= '0;
    end else begin
      clk_filt_q <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        fcnt     <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign fall    = clk_filt_q & ~clk_filt;
  assign data_s  = data_sync[1];
  assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    if (timeout) begin
      state_next = IDLE;
      frame_bad  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:    if (data_s) frame_bad = 1'b1;
                 else        state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP: begin
          state_next = IDLE;
          if (data_s && (^{shreg, par_bit})) frame_ok  = 1'b1;
          else                               frame_bad = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Frame datapath and timeout counter (saturates, cleared by each edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (fall) tcnt <= '0;
      else if ((state != IDLE) && (tcnt != TW'(TIMEOUT_CYCLES))) tcnt <= tcnt + 1'b1;

      if (fall && !timeout) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: par_bit <= data_s;
          default: ;
        endcase
      end

      scan_valid <= frame_ok;
      frame_err  <= frame_bad;
      if (frame_ok) scan_code <= shreg;
    end
  end

  // Protocol layer: acts in the scan_valid cycle, key outputs land one later.
  always_ff @(posedge clk) begin
    if (rst) begin
      brk         <= 1'b0;
      ext         <= 1'b0;
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      if (frame_err) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (scan_valid) begin
        if (scan_code == 8'hE0) begin
          ext <= 1'b1;
        end else if (scan_code == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if ((scan_code == KEY_CODES[8*i +: 8]) && (ext == KEY_EXT[i])) begin
              if (!brk && !key_held[i]) begin
                key_held[i]  <= 1'b1;
                key_press[i] <= 1'b1;
              end else if (brk && key_held[i]) begin
                key_held[i]    <= 1'b0;
                key_release[i] <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed self-checking bench for ps2_key_decoder.
// PS/2 bit timing and the timeout are shortened so the whole run stays short.
module tb_ps2_key_decoder;

  localparam int HALF = 20;   // clk cycles per PS/2 clock half period
  localparam int GAP  = 60;   // idle clk cycles between frames

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] key_held, key_press, key_release;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;

  ps2_key_decoder #(
    .NUM_KEYS       (4),
    .KEY_CODES      ({8'h72, 8'h75, 8'h76, 8'h29}),
    .KEY_EXT        (4'b0100),
    .TIMEOUT_CYCLES (200),
    .FILTER_LEN     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .frame_err   (frame_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling clk edge.
  int         sv_cnt = 0, fe_cnt = 0, viol = 0;
  int         press_cnt [4] = '{0, 0, 0, 0};
  int         rel_cnt   [4] = '{0, 0, 0, 0};
  logic       sv_q = 1'b0, fe_q = 1'b0;
  logic [3:0] pr_q = '0, rl_q = '0;

  always @(negedge clk) begin
    if (scan_valid) sv_cnt <= sv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    // key pulses must follow scan_valid by one cycle; no pulse wider than 1
    if (((|key_press || |key_release) && !sv_q) ||
        (scan_valid && sv_q) || (frame_err && fe_q) ||
        (|(key_press & pr_q)) || (|(key_release & rl_q)) ||
        (|(key_press & key_release)))
      viol <= viol + 1;
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] <= press_cnt[i] + int'(key_press[i]);
      rel_cnt[i]   <= rel_cnt[i] + int'(key_release[i]);
    end
    sv_q <= scan_valid;
    fe_q <= frame_err;
    pr_q <= key_press;
    rl_q <= key_release;
  end

  int sv0, fe0;
  int pr0 [4];
  int rl0 [4];

  task automatic snap;
    sv0 = sv_cnt;
    fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) begin
      pr0[i] = press_cnt[i];
      rl0[i] = rel_cnt[i];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic        par;
    logic [10:0] bits;
    par = ~^b;
    if (bad_par) par = ~par;
    bits = {1'b1, par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    ps2_data = 1'b1;
    tick(GAP);
  endtask

  function automatic int press_sum();
    return (press_cnt[0] - pr0[0]) + (press_cnt[1] - pr0[1]) +
           (press_cnt[2] - pr0[2]) + (press_cnt[3] - pr0[3]);
  endfunction

  function automatic int rel_sum();
    return (rel_cnt[0] - rl0[0]) + (rel_cnt[1] - rl0[1]) +
           (rel_cnt[2] - rl0[2]) + (rel_cnt[3] - rl0[3]);
  endfunction

  initial begin
    tick(5);
    check("reset_held",    32'(key_held),    32'h0);
    check("reset_press",   32'(key_press),   32'h0);
    check("reset_release", 32'(key_release), 32'h0);
    check("reset_code",    32'(scan_code),   32'h0);
    check("reset_valid",   32'(scan_valid),  32'h0);
    check("reset_err",     32'(frame_err),   32'h0);
    rst = 1'b0;
    tick(20);

    // make then break of space
    snap();
    send_frame(8'h29, 0);
    check("make_sv",    sv_cnt - sv0, 1);
    check("make_code",  32'(scan_code), 32'h29);
    check("make_press", press_cnt[0] - pr0[0], 1);
    check("make_held",  32'(key_held), 32'h1);
    send_frame(8'hF0, 0);
    check("f0_no_rel",  rel_sum(), 0);
    send_frame(8'h29, 0);
    check("brk_rel",    rel_cnt[0] - rl0[0], 1);
    check("brk_held",   32'(key_held), 32'h0);
    check("brk_sv",     sv_cnt - sv0, 3);
    check("brk_noerr",  fe_cnt - fe0, 0);

    // typematic repeat
    snap();
    for (int i = 0; i < 3; i++) send_frame(8'h29, 0);
    check("rep_press", press_cnt[0] - pr0[0], 1);
    check("rep_held",  32'(key_held), 32'h1);
    check("rep_sv",    sv_cnt - sv0, 3);
    send_frame(8'hF0, 0);
    send_frame(8'h29, 0);
    check("rep_rel_held", 32'(key_held), 32'h0);

    // parity error, then a good esc
    snap();
    send_frame(8'h76, 1);
    check("par_err",  fe_cnt - fe0, 1);
    check("par_sv",   sv_cnt - sv0, 0);
    check("par_held", 32'(key_held), 32'h0);
    send_frame(8'h76, 0);
    check("esc_press", press_cnt[1] - pr0[1], 1);
    check("esc_held",  32'(key_held), 32'h2);

    // extended slot 2
    snap();
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    check("ext_press", press_cnt[2] - pr0[2], 1);
    check("ext_held",  32'(key_held), 32'h6);
    snap();
    send_frame(8'h75, 0);
    check("plain75_press", press_sum(), 0);
    check("plain75_rel",   rel_sum(), 0);
    check("plain75_sv",    sv_cnt - sv0, 1);
    check("plain75_held",  32'(key_held), 32'h6);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    check("ext_rel",      rel_cnt[2] - rl0[2], 1);
    check("ext_rel_held", 32'(key_held), 32'h2);

    // partial frame abandoned by timeout
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    tick(400);
    check("to_err", fe_cnt - fe0, 1);
    check("to_sv",  sv_cnt - sv0, 0);
    send_frame(8'h29, 0);
    check("to_next_press", press_cnt[0] - pr0[0], 1);
    check("to_next_code",  32'(scan_code), 32'h29);
    check("to_next_held",  32'(key_held), 32'h3);

    // single-cycle glitch on an idle bus
    snap();
    ps2_clk = 1'b0;
    tick(1);
    ps2_clk = 1'b1;
    tick(50);
    check("glitch_sv",  sv_cnt - sv0, 0);
    check("glitch_err", fe_cnt - fe0, 0);

    // reset in the middle of a frame
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b0;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF / 2);
    rst = 1'b1;
    tick(1);
    check("mid_rst_held", 32'(key_held), 32'h0);
    check("mid_rst_code", 32'(scan_code), 32'h0);
    check("mid_rst_misc", 32'({key_press, key_release, scan_valid, frame_err}), 32'h0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick(10);
    rst = 1'b0;
    tick(20);
    send_frame(8'h29, 0);
    check("post_rst_press", press_cnt[0] - pr0[0], 1);
    check("post_rst_held",  32'(key_held), 32'h1);
    check("post_rst_code",  32'(scan_code), 32'h29);
    check("post_rst_err",   fe_cnt - fe0, 0);

    check("pulse_shape", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
